cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Round-robin arbiter that shares the single CPU-side request port of cache_top between NUM_REQ requesters, for example instruction fetch and load/store.
- Allows one outstanding transaction at a time.
- Registers the winning request, issues it to the cache, waits for the cache response, then routes that response back to the owning requester.
- Sits between the core-side masters and cache_top.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with CACHE_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_rw  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_wstrb  in  NUM_REQ*DATA_W/8  packed byte strobes.
- resp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- resp_rdata  out  DATA_W  response data, shared by all requesters and qualified by resp_valid.
- cpu_req_valid  out  1  to cache_top.
- cpu_req_ready  in  1  from cache_top.
- cpu_req_rw  out  1  to cache_top.
- cpu_addr  out  ADDR_W  to cache_top.
- cpu_wdata  out  DATA_W  to cache_top.
- cpu_wstrb  out  DATA_W/8  to cache_top.
- cpu_resp_valid  in  1  from cache_top.
- cpu_rdata  in  DATA_W  from cache_top.
- timeout_err  out  1  one-cycle watchdog pulse; held 0 without the macro.

Behaviour:
- Clocking: one clock, clk. rst_n is asynchronous assert, active-low.
- Reset state: FSM=IDLE, rr_ptr=0.
- Reset output values: all outputs 0, including req_ready, resp_valid, resp_rdata, cpu_req_valid, the cpu_* fields and timeout_err.
- FSM states: IDLE, ISSUE, WAIT.
- Arbitration (combinational): grant is one-hot. It goes to the first asserted req_valid searching from index rr_ptr upward, modulo NUM_REQ.
- req_ready[i] = (state==IDLE) && grant[i].
- A requester transfer occurs when req_valid[i] && req_ready[i].
- Requester obligation: a requester holds its fields stable while its valid is high and ready is low.
- IDLE → ISSUE on a transfer:
  - Register rw, addr, wdata and wstrb of the granted requester.
  - Record the owner index.
- ISSUE:
  - cpu_req_valid=1, driven from the registered fields only; there is no combinational path from the req_* inputs to the cpu_* outputs.
  - Hold until cpu_req_valid && cpu_req_ready. In that cycle the cache accepts the request; next state is WAIT and cpu_req_valid=0.
- WAIT:
  - On cpu_resp_valid, assert resp_valid[owner]=1 and resp_rdata=cpu_rdata, registered, in the next cycle.
  - At the same time set rr_ptr=(owner+1) mod NUM_REQ and return to IDLE.
  - Writes also complete on cpu_resp_valid, and their response pulse is forwarded the same way.
- Latency:
  - Requester transfer to cpu_req_valid high: 1 cycle.
  - cpu_resp_valid to resp_valid: 1 cycle.
  - Minimum spacing between successive grants: response cycle + 1.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Single requester valid: it wins regardless of rr_ptr.
- Simultaneous response and new request: in the resp_valid cycle the state is IDLE, so a new request may be accepted in that same cycle. Arbitration uses the updated rr_ptr.
- Stray responses: cpu_resp_valid while in IDLE or ISSUE is ignored and produces no resp_valid.
- Only one resp_valid bit is ever high at a time.
- Reset mid-operation: returns to IDLE immediately and drops cpu_req_valid. Any cache response arriving later is ignored as a stray response.

Optional Feature:
- Macro: CACHE_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter is cleared on entry to WAIT and counts while in WAIT.
  - When it reaches TIMEOUT_CYCLES without cpu_resp_valid, assert timeout_err for 1 cycle.
  - At the same time assert resp_valid[owner] with resp_rdata=32'hDEAD_BEEF, advance rr_ptr and return to IDLE.
  - A response arriving on the exact timeout cycle takes priority: normal data is returned and timeout_err is not asserted.
- Without the macro: no counter; WAIT waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Reset then single read: req0 read addr 0x44; cache model returns 0x1111_0004 after 8 cycles → cpu_addr=0x44, cpu_req_rw=0 one cycle after accept; resp_valid=2'b01 with rdata 0x1111_0004 one cycle after cpu_resp_valid; resp_valid[1] stays 0.
- Contention: req0 and req1 valid continuously, reads to 0x100 and 0x200 → cpu_addr sequence 0x100,0x200,0x100,0x200; each resp_valid pulse goes to the matching owner.
- Write pass-through: req1 write addr 0x44 data 0xAA strobe 4'b0001 → cpu_req_rw=1, cpu_wdata=0xAA, cpu_wstrb=4'b0001; resp_valid=2'b10 pulse.
- Backpressure: cpu_req_ready held low 5 cycles during ISSUE → cpu_req_valid stays high and cpu_addr stable for all 5 cycles; req_ready stays 0 for both requesters.
- Reset mid-WAIT: assert rst_n=0 while in WAIT, release, then cache pulses cpu_resp_valid → no resp_valid; next req0 read completes normally.
- CACHE_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, cache never responds → timeout_err pulses 16 cycles after WAIT entry; owner gets resp_rdata 0xDEAD_BEEF; FSM returns to IDLE.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the cache_top CPU request port between NUM_REQ requesters,
// one outstanding transaction at a time. Optional watchdog in WAIT: define CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic                         cpu_req_valid,
    input  logic                         cpu_req_ready,
    output logic                         cpu_req_rw,
    output logic [ADDR_W-1:0]            cpu_addr,
    output logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W/8-1:0]          cpu_wstrb,
    input  logic                         cpu_resp_valid,
    input  logic [DATA_W-1:0]            cpu_rdata,
    output logic                         timeout_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cache_req_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, owner_q, grant_idx, next_ptr;
    logic [NUM_REQ-1:0]   grant, owner_oh, resp_valid_q;
    logic                 found, xfer, resp_fire, timeout_fire;
    int                   idx;
    logic                 rw_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q, rdata_q;
    logic [STRB_W-1:0]    wstrb_q;

    // Search from rr_ptr upward, wrapping; the first valid requester wins.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                found      = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign owner_oh  = NUM_REQ'(1) << owner_q;
    assign next_ptr  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;
`endif

    always_comb begin
        state_d      = state_q;
        resp_fire    = 1'b0;
        timeout_fire = 1'b0;
        case (state_q)
            IDLE:  if (xfer) state_d = ISSUE;
            ISSUE: if (cpu_req_ready) state_d = WAIT;
            WAIT: begin
                if (cpu_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                // A response on the final watchdog cycle wins over the timeout.
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_fire = 1'b1;
                    state_d      = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= '0;
            if (state_q == IDLE && xfer) begin
                owner_q <= grant_idx;
                rw_q    <= req_rw[grant_idx];
                addr_q  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                wdata_q <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                wstrb_q <= req_wstrb[int'(grant_idx)*STRB_W +: STRB_W];
            end
            if (resp_fire || timeout_fire) begin
                resp_valid_q <= owner_oh;
                rdata_q      <= resp_fire ? cpu_rdata : DATA_W'(32'hDEAD_BEEF);
                rr_ptr_q     <= next_ptr;
            end
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (state_q == ISSUE && cpu_req_ready) tmo_cnt_q <= '0;
            else if (state_q == WAIT)              tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // The cache only ever sees registered fields, never the live req_* inputs.
    assign cpu_req_valid = (state_q == ISSUE);
    assign cpu_req_rw    = rw_q;
    assign cpu_addr      = addr_q;
    assign cpu_wdata     = wdata_q;
    assign cpu_wstrb     = wstrb_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: table of transactions plus hand-written reset,
// stray-response and (with CACHE_ARB_TIMEOUT_EN) watchdog sequences.
module tb_cache_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int TMO     = 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid, req_ready, req_rw, resp_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ*STRB_W-1:0]   req_wstrb;
    logic [DATA_W-1:0]           resp_rdata, cpu_wdata, cpu_rdata;
    logic                        cpu_req_valid, cpu_req_ready, cpu_req_rw;
    logic [ADDR_W-1:0]           cpu_addr;
    logic [STRB_W-1:0]           cpu_wstrb;
    logic                        cpu_resp_valid, timeout_err;

    cache_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_rw(cpu_req_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  rw;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        logic [3:0]  wstrb0, wstrb1;
        int          lat;
        int          bp;
        logic [31:0] rdata;
        logic [1:0]  exp_grant;
        logic [31:0] exp_addr;
        logic        exp_rw;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[9];
    vec_t post;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] rw,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic [3:0] ws0, input logic [3:0] ws1,
                                input int lat, input int bp, input logic [31:0] rdata,
                                input logic [1:0] g, input logic [31:0] ea, input logic erw,
                                input logic [31:0] ewd, input logic [3:0] ews);
        vec_t v;
        v.valid = valid; v.rw = rw; v.addr0 = a0; v.addr1 = a1;
        v.wdata0 = wd0; v.wdata1 = wd1; v.wstrb0 = ws0; v.wstrb1 = ws1;
        v.lat = lat; v.bp = bp; v.rdata = rdata; v.exp_grant = g;
        v.exp_addr = ea; v.exp_rw = erw; v.exp_wdata = ewd; v.exp_wstrb = ews;
        return v;
    endfunction

    // Runs one transaction from requester drive to response pulse, acting as the cache.
    task automatic run_vec(input int n, input vec_t v);
        int t;
        req_valid = v.valid;
        req_rw    = v.rw;
        req_addr  = {v.addr1, v.addr0};
        req_wdata = {v.wdata1, v.wdata0};
        req_wstrb = {v.wstrb1, v.wstrb0};
        #1;
        t = 0;
        while ((req_valid & req_ready) == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d grant", n), req_ready, v.exp_grant);
        if ((req_valid & req_ready) == '0) return;
        @(negedge clk);
        req_valid = req_valid & ~v.exp_grant;
        check($sformatf("v%0d cpu_req_valid", n), cpu_req_valid, 1);
        check($sformatf("v%0d cpu_addr", n), cpu_addr, v.exp_addr);
        check($sformatf("v%0d cpu_req_rw", n), cpu_req_rw, v.exp_rw);
        check($sformatf("v%0d cpu_wdata", n), cpu_wdata, v.exp_wdata);
        check($sformatf("v%0d cpu_wstrb", n), cpu_wstrb, v.exp_wstrb);
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            check($sformatf("v%0d bp%0d cpu_req_valid", n, i), cpu_req_valid, 1);
            check($sformatf("v%0d bp%0d cpu_addr", n, i), cpu_addr, v.exp_addr);
            check($sformatf("v%0d bp%0d req_ready", n, i), req_ready, 0);
        end
        cpu_req_ready = 1'b1;
        @(negedge clk);
        cpu_req_ready = 1'b0;
        check($sformatf("v%0d wait cpu_req_valid", n), cpu_req_valid, 0);
        for (int i = 0; i < v.lat - 1; i++) begin
            check($sformatf("v%0d early resp_valid", n), resp_valid, 0);
            @(negedge clk);
        end
        cpu_resp_valid = 1'b1;
        cpu_rdata      = v.rdata;
        @(negedge clk);
        cpu_resp_valid = 1'b0;
        check($sformatf("v%0d resp_valid", n), resp_valid, v.exp_grant);
        check($sformatf("v%0d resp_rdata", n), resp_rdata, v.rdata);
        check($sformatf("v%0d timeout_err", n), timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            valid  rw     addr0   addr1   wd0    wd1    ws0    ws1    lat bp rdata          grant  addr    rw wdata  wstrb
        vecs[0] = mk(2'b01, 2'b00, 32'h44,  32'h0,  32'h0, 32'h0,  4'h0, 4'h0, 8, 0, 32'h1111_0004, 2'b01, 32'h44,  0, 32'h0,  4'h0);
        vecs[1] = mk(2'b10, 2'b10, 32'h0,   32'h44, 32'h55, 32'hAA, 4'hF, 4'h1, 3, 0, 32'h0000_0000, 2'b10, 32'h44,  1, 32'hAA, 4'h1);
        vecs[2] = mk(2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0,  4'h0, 4'h0, 2, 0, 32'hA0A0_0100, 2'b01, 32'h100, 0, 32'h0,  4'h0);
        vecs[3] = mk(2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0,  4'h0, 4'h0, 2, 0, 32'hB0B0_0200, 2'b10, 32'h200, 0, 32'h0,  4'h0);
        vecs[4] = mk(2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0,  4'h0, 4'h0, 1, 0, 32'hA0A0_0101, 2'b01, 32'h100, 0, 32'h0,  4'h0);
        vecs[5] = mk(2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0,  4'h0, 4'h0, 4, 0, 32'hB0B0_0201, 2'b10, 32'h200, 0, 32'h0,  4'h0);
        vecs[6] = mk(2'b10, 2'b00, 32'h100, 32'h280, 32'h0, 32'h0,  4'h0, 4'h0, 2, 0, 32'hC0C0_0280, 2'b10, 32'h280, 0, 32'h0,  4'h0);
        vecs[7] = mk(2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0,  4'h0, 4'h0, 2, 5, 32'h0300_0300, 2'b01, 32'h300, 0, 32'h0,  4'h0);
        vecs[8] = mk(2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0,  4'h0, 4'h0, 1, 0, 32'h0400_0400, 2'b10, 32'h400, 0, 32'h0,  4'h0);
        post    = mk(2'b01, 2'b00, 32'h600, 32'h0,  32'h0, 32'h0,  4'h0, 4'h0, 3, 0, 32'h0600_0600, 2'b01, 32'h600, 0, 32'h0,  4'h0);

        rst_n = 1'b0;
        req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        cpu_req_ready = 1'b0; cpu_resp_valid = 1'b0; cpu_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst req_ready", req_ready, 0);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_rdata", resp_rdata, 0);
        check("rst cpu_req_valid", cpu_req_valid, 0);
        check("rst cpu_req_rw", cpu_req_rw, 0);
        check("rst cpu_addr", cpu_addr, 0);
        check("rst cpu_wdata", cpu_wdata, 0);
        check("rst cpu_wstrb", cpu_wstrb, 0);
        check("rst timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
        req_valid = '0;
        @(negedge clk);

        // Stray response while idle.
        cpu_resp_valid = 1'b1;
        cpu_rdata      = 32'hBAD0_0001;
        @(negedge clk);
        cpu_resp_valid = 1'b0;
        check("stray idle resp_valid", resp_valid, 0);

        // Stray response in ISSUE, then reset while in WAIT and a late response.
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h500};
        req_rw    = 2'b00;
        #1;
        for (int t = 0; t < 20 && req_ready[0] !== 1'b1; t++) @(negedge clk);
        check("rw grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid      = '0;
        cpu_resp_valid = 1'b1;
        cpu_rdata      = 32'hBAD0_0002;
        @(negedge clk);
        cpu_resp_valid = 1'b0;
        check("stray issue resp_valid", resp_valid, 0);
        check("stray issue cpu_req_valid", cpu_req_valid, 1);
        cpu_req_ready = 1'b1;
        @(negedge clk);
        cpu_req_ready = 1'b0;
        check("rw wait cpu_req_valid", cpu_req_valid, 0);
        rst_n = 1'b0;
        #1;
        check("rw in-reset cpu_addr", cpu_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_resp_valid = 1'b1;
        cpu_rdata      = 32'hBAD0_0003;
        @(negedge clk);
        cpu_resp_valid = 1'b0;
        check("late resp after reset", resp_valid, 0);
        check("late resp rdata", resp_rdata, 0);
        run_vec(9, post);

`ifdef CACHE_ARB_TIMEOUT_EN
        // Cache never answers: watchdog fires 16 cycles after WAIT entry.
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h700};
        #1;
        for (int t = 0; t < 20 && req_ready[0] !== 1'b1; t++) @(negedge clk);
        check("tmo grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid     = '0;
        cpu_req_ready = 1'b1;
        @(negedge clk);
        cpu_req_ready = 1'b0;
        check("tmo wait0 timeout_err", timeout_err, 0);
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            check($sformatf("tmo wait%0d timeout_err", k), timeout_err, 0);
        end
        @(negedge clk);
        check("tmo timeout_err", timeout_err, 1);
        check("tmo resp_valid", resp_valid, 2'b01);
        check("tmo resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h704};
        #1;
        check("tmo back to idle", req_ready, 2'b01);
        @(negedge clk);
        check("tmo pulse width", timeout_err, 0);
        check("tmo next issue", cpu_req_valid, 1);
        // Response on the exact timeout cycle takes priority.
        req_valid     = '0;
        cpu_req_ready = 1'b1;
        @(negedge clk);
        cpu_req_ready = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        cpu_resp_valid = 1'b1;
        cpu_rdata      = 32'h1234_5678;
        @(negedge clk);
        cpu_resp_valid = 1'b0;
        check("prio resp_valid", resp_valid, 2'b01);
        check("prio resp_rdata", resp_rdata, 32'h1234_5678);
        check("prio timeout_err", timeout_err, 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
